trojan_trigger_monitor: RTL and testbench

- Run-time detector for gate-level trojans of the AND-tree-trigger / XOR-payload type inserted into the benchmark netlists.
- Taps up to N candidate trigger nets and one victim net alongside its golden (trojan-free) value.
- Flags a coincidence of all trigger nets at their rare values, then checks whether the victim diverges within a window.
- Raises a sticky alarm with a snapshot, a cause code and counters.
- Sits beside the device under test as the observing end of the trigger/payload path.

---
 rtl/trojan_trigger_monitor.sv | 161 ++++++++++++++++
 tb/tb_trojan_trigger_monitor.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trojan_trigger_monitor.sv
// Watches N_TRIG trigger nets for an all-rare coincidence and checks for a victim payload mismatch afterwards.
// Optional TSTAMP output (cycle stamp of the latest snapshot) is enabled by defining TRIG_MON_TIMESTAMP_EN.
module trojan_trigger_monitor #(
    parameter int N_TRIG = 8,
    parameter int WINDOW = 4,
    parameter int THRESH = 3,
    parameter int CNT_W  = 16
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              EN,
    input  logic              CLR,
    input  logic [N_TRIG-1:0] TRIG_NETS,
    input  logic [N_TRIG-1:0] RARE_MASK,
    input  logic              VICTIM_OBS,
    input  logic              VICTIM_GOLD,
    input  logic              ACK,
    output logic              ALARM,
    output logic [1:0]        CAUSE,
    output logic [N_TRIG-1:0] SNAPSHOT,
    output logic [CNT_W-1:0]  HIT_CNT,
    output logic [CNT_W-1:0]  MIS_CNT,
    output logic [1:0]        STATE
`ifdef TRIG_MON_TIMESTAMP_EN
    ,
    output logic [CNT_W-1:0]  TSTAMP
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_SUSPECT = 2'd2,
        S_ALARMED = 2'd3
    } state_t;

    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW - 1);

    state_t            state_q;
    logic              alarm_q;
    logic [1:0]        cause_q;
    logic [N_TRIG-1:0] snap_q;
    logic [WIN_W-1:0]  win_q;
    logic [N_TRIG-1:0] trig_q;
    logic              vobs_q;
    logic              vgold_q;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  mis_cnt_q, mis_cnt_d;
    logic [CNT_W:0]    hit_nxt;
    logic              hit_s, mis_s, thr_s, counting, snap_upd;

    assign hit_s    = (trig_q == RARE_MASK);
    assign mis_s    = vobs_q ^ vgold_q;
    assign hit_nxt  = {1'b0, hit_cnt_q} + (CNT_W+1)'(1);
    assign thr_s    = int'(hit_nxt) >= THRESH;
    assign counting = (state_q == S_ARMED) || (state_q == S_SUSPECT);
    assign snap_upd = counting && EN && hit_s;

    always_ff @(posedge CK) begin
        if (RST) begin
            trig_q  <= '0;
            vobs_q  <= 1'b0;
            vgold_q <= 1'b0;
        end else begin
            trig_q  <= TRIG_NETS;
            vobs_q  <= VICTIM_OBS;
            vgold_q <= VICTIM_GOLD;
        end
    end

    // Saturating counters; CLR wins over any increment.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (CLR) begin
            hit_cnt_d = '0;
            mis_cnt_d = '0;
        end else if (counting) begin
            if (hit_s && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + CNT_W'(1);
            if (mis_s && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            hit_cnt_q <= '0;
            mis_cnt_q <= '0;
            snap_q    <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
            mis_cnt_q <= mis_cnt_d;
            if (snap_upd) snap_q <= trig_q;
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= S_IDLE;
            alarm_q <= 1'b0;
            cause_q <= 2'b00;
            win_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (EN) state_q <= S_ARMED;
                end
                S_ARMED, S_SUSPECT: begin
                    if (!EN) begin
                        state_q <= S_IDLE;
                    end else if ((hit_s && (thr_s || mis_s)) ||
                                 (state_q == S_SUSPECT && mis_s)) begin
                        state_q <= S_ALARMED;
                        alarm_q <= 1'b1;
                        cause_q <= {hit_s && thr_s, mis_s};
                    end else if (hit_s) begin
                        state_q <= S_SUSPECT;
                        win_q   <= WIN_LOAD;
                    end else if (state_q == S_SUSPECT) begin
                        if (win_q == '0) state_q <= S_ARMED;
                        else             win_q   <= win_q - WIN_W'(1);
                    end
                end
                S_ALARMED: begin
                    // Sticky until acknowledged; EN only picks where to resume.
                    if (ACK) begin
                        state_q <= EN ? S_ARMED : S_IDLE;
                        alarm_q <= 1'b0;
                        cause_q <= 2'b00;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef TRIG_MON_TIMESTAMP_EN
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] tstamp_q;

    always_ff @(posedge CK) begin
        if (RST) begin
            cyc_q    <= '0;
            tstamp_q <= '0;
        end else begin
            cyc_q <= cyc_q + CNT_W'(1);
            if (snap_upd) tstamp_q <= cyc_q;
        end
    end

    assign TSTAMP = tstamp_q;
`endif

    assign ALARM    = alarm_q;
    assign CAUSE    = cause_q;
    assign SNAPSHOT = snap_q;
    assign HIT_CNT  = hit_cnt_q;
    assign MIS_CNT  = mis_cnt_q;
    assign STATE    = state_q;

endmodule

// File: tb/tb_trojan_trigger_monitor.sv
module tb_trojan_trigger_monitor;

    localparam int WINDOW = 4;
    localparam int THRESH = 3;
    localparam int MAXC   = 65535;

    logic       CK = 1'b0;
    logic       RST = 1'b1, EN = 1'b0, CLR = 1'b0, ACK = 1'b0;
    logic [7:0] TRIG_NETS = 8'h00, RARE_MASK = 8'hFF;
    logic       VICTIM_OBS = 1'b0, VICTIM_GOLD = 1'b0;

    logic        ALARM;
    logic [1:0]  CAUSE, STATE;
    logic [7:0]  SNAPSHOT;
    logic [15:0] HIT_CNT, MIS_CNT;

    logic        s_alarm;
    logic [1:0]  s_cause, s_state;
    logic [7:0]  s_snap;
    logic [3:0]  s_hit, s_mis;
`ifdef TRIG_MON_TIMESTAMP_EN
    logic [15:0] TSTAMP;
    logic [3:0]  s_ts;
`endif

    int checks = 0;
    int failures = 0;
    bit mdl_on = 1'b0;

    always #5 CK = ~CK;

    trojan_trigger_monitor #(.N_TRIG(8), .WINDOW(WINDOW), .THRESH(THRESH), .CNT_W(16)) dut (
        .CK(CK), .RST(RST), .EN(EN), .CLR(CLR),
        .TRIG_NETS(TRIG_NETS), .RARE_MASK(RARE_MASK),
        .VICTIM_OBS(VICTIM_OBS), .VICTIM_GOLD(VICTIM_GOLD), .ACK(ACK),
        .ALARM(ALARM), .CAUSE(CAUSE), .SNAPSHOT(SNAPSHOT),
        .HIT_CNT(HIT_CNT), .MIS_CNT(MIS_CNT), .STATE(STATE)
`ifdef TRIG_MON_TIMESTAMP_EN
        , .TSTAMP(TSTAMP)
`endif
    );

    // Narrow-counter instance used only for saturation.
    trojan_trigger_monitor #(.N_TRIG(8), .WINDOW(WINDOW), .THRESH(31), .CNT_W(4)) dut_sat (
        .CK(CK), .RST(RST), .EN(EN), .CLR(CLR),
        .TRIG_NETS(TRIG_NETS), .RARE_MASK(RARE_MASK),
        .VICTIM_OBS(VICTIM_OBS), .VICTIM_GOLD(VICTIM_GOLD), .ACK(ACK),
        .ALARM(s_alarm), .CAUSE(s_cause), .SNAPSHOT(s_snap),
        .HIT_CNT(s_hit), .MIS_CNT(s_mis), .STATE(s_state)
`ifdef TRIG_MON_TIMESTAMP_EN
        , .TSTAMP(s_ts)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 off, 1 watching, 2 waiting for payload, 3 alarm latched.
    int         m_mode, m_left, m_hit, m_mis, m_cyc, m_ts;
    logic [1:0] m_cause;
    logic [7:0] m_snap, p_trig;
    logic       p_vo, p_vg;

    always @(posedge CK) begin : model
        logic hit, mis, thr;
        int   nh, nm;
        if (RST) begin
            m_mode <= 0; m_left <= 0; m_hit <= 0; m_mis <= 0; m_cyc <= 0; m_ts <= 0;
            m_cause <= 2'b00; m_snap <= 8'h00; p_trig <= 8'h00; p_vo <= 1'b0; p_vg <= 1'b0;
        end else begin
            hit = (p_trig == RARE_MASK);
            mis = (p_vo != p_vg);
            thr = (m_hit + 1 >= THRESH);
            nh = m_hit;
            nm = m_mis;
            if (CLR) begin
                nh = 0;
                nm = 0;
            end else if (m_mode == 1 || m_mode == 2) begin
                if (hit) nh = (nh + 1 > MAXC) ? MAXC : nh + 1;
                if (mis) nm = (nm + 1 > MAXC) ? MAXC : nm + 1;
            end
            m_hit <= nh;
            m_mis <= nm;
            m_cyc <= (m_cyc + 1) % 65536;
            if ((m_mode == 1 || m_mode == 2) && EN && hit) begin
                m_snap <= p_trig;
                m_ts   <= m_cyc;
            end
            if (m_mode == 0) begin
                if (EN) m_mode <= 1;
            end else if (m_mode == 3) begin
                if (ACK) begin
                    m_mode  <= EN ? 1 : 0;
                    m_cause <= 2'b00;
                end
            end else if (!EN) begin
                m_mode <= 0;
            end else if ((hit && (thr || mis)) || (m_mode == 2 && mis)) begin
                m_mode  <= 3;
                m_cause <= {hit && thr, mis};
            end else if (hit) begin
                m_mode <= 2;
                m_left <= WINDOW;
            end else if (m_mode == 2) begin
                if (m_left == 1) m_mode <= 1;
                m_left <= m_left - 1;
            end
            p_trig <= TRIG_NETS;
            p_vo   <= VICTIM_OBS;
            p_vg   <= VICTIM_GOLD;
        end
    end

    always @(negedge CK) begin
        if (mdl_on) begin
            chk("mdl_state", STATE, m_mode);
            chk("mdl_alarm", ALARM, (m_mode == 3));
            chk("mdl_cause", CAUSE, m_cause);
            chk("mdl_snapshot", SNAPSHOT, m_snap);
            chk("mdl_hit_cnt", HIT_CNT, m_hit);
            chk("mdl_mis_cnt", MIS_CNT, m_mis);
`ifdef TRIG_MON_TIMESTAMP_EN
            chk("mdl_tstamp", TSTAMP, m_ts);
`endif
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CK);
    endtask

    // Ends just after the second post-reset edge with the monitor ARMED.
    task automatic do_reset();
        RST = 1'b1;
        repeat (3) begin
            TRIG_NETS = 8'($urandom); VICTIM_OBS = 1'($urandom); VICTIM_GOLD = 1'($urandom);
            EN = 1'($urandom); ACK = 1'($urandom); CLR = 1'($urandom);
            tick();
        end
        mdl_on = 1'b1;
        chk("rst_state", STATE, 0);
        chk("rst_alarm", ALARM, 0);
        chk("rst_cause", CAUSE, 0);
        chk("rst_hit_cnt", HIT_CNT, 0);
        chk("rst_mis_cnt", MIS_CNT, 0);
        chk("rst_snapshot", SNAPSHOT, 0);
        RST = 1'b0; EN = 1'b0; ACK = 1'b0; CLR = 1'b0;
        TRIG_NETS = 8'h00; VICTIM_OBS = 1'b0; VICTIM_GOLD = 1'b0;
        tick();
        EN = 1'b1;
        tick();
        chk("arm_state", STATE, 1);
    endtask

    task automatic hit_pulse();
        TRIG_NETS = 8'hFF;
        tick();
        TRIG_NETS = 8'h00;
        tick();
    endtask

    initial begin
        int n2, na;
        tick();

        // Threshold alarm
        do_reset();
        hit_pulse();
        chk("thr_p1_suspect", STATE, 2);
        tick(8);
        chk("thr_p1_back_armed", STATE, 1);
        hit_pulse();
        chk("thr_p2_suspect", STATE, 2);
        tick(8);
        chk("thr_p2_back_armed", STATE, 1);
        hit_pulse();
        chk("thr_state", STATE, 3);
        chk("thr_alarm", ALARM, 1);
        chk("thr_cause", CAUSE, 2'b10);
        chk("thr_hit_cnt", HIT_CNT, 3);
        chk("thr_snapshot", SNAPSHOT, 8'hFF);

        // Payload alarm, then sticky with EN low
        do_reset();
        TRIG_NETS = 8'hFF;
        tick();
        TRIG_NETS = 8'h00;
        tick();
        VICTIM_OBS = 1'b1;
        tick();
        VICTIM_OBS = 1'b0;
        chk("pay_not_yet", ALARM, 0);
        tick();
        chk("pay_alarm", ALARM, 1);
        chk("pay_cause", CAUSE, 2'b01);
        chk("pay_mis_cnt", MIS_CNT, 1);
        EN = 1'b0;
        tick(3);
        chk("pay_sticky_alarm", ALARM, 1);
        chk("pay_sticky_state", STATE, 3);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("pay_ack_idle", STATE, 0);
        chk("pay_ack_alarm", ALARM, 0);

        // Window expiry
        do_reset();
        TRIG_NETS = 8'hFF;
        tick();
        TRIG_NETS = 8'h00;
        n2 = 0; na = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (STATE == 2'd2) n2++;
            if (ALARM) na++;
        end
        chk("win_suspect_cycles", n2, 4);
        chk("win_no_alarm", na, 0);
        tick(6);
        VICTIM_OBS = 1'b1;
        tick();
        VICTIM_OBS = 1'b0;
        tick();
        chk("win_late_mis_cnt", MIS_CNT, 1);
        chk("win_late_alarm", ALARM, 0);
        chk("win_late_state", STATE, 1);

        // Simultaneous hit+mismatch, ACK, CLR
        do_reset();
        hit_pulse();
        tick(8);
        hit_pulse();
        tick(8);
        chk("sim_pre_hits", HIT_CNT, 2);
        TRIG_NETS = 8'hFF; VICTIM_OBS = 1'b1;
        tick();
        TRIG_NETS = 8'h00; VICTIM_OBS = 1'b0;
        tick();
        chk("sim_cause", CAUSE, 2'b11);
        chk("sim_state", STATE, 3);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("sim_ack_state", STATE, 1);
        chk("sim_ack_alarm", ALARM, 0);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        chk("clr_hit_cnt", HIT_CNT, 0);
        chk("clr_state_kept", STATE, 1);
        TRIG_NETS = 8'hFF;
        tick();
        TRIG_NETS = 8'h00; CLR = 1'b1;
        tick();
        CLR = 1'b0;
        chk("clr_with_hit_cnt", HIT_CNT, 0);
        chk("clr_with_hit_state", STATE, 2);

        // Saturation on the narrow instance
        do_reset();
        for (int i = 0; i < 20; i++) begin
            hit_pulse();
            if (ALARM) begin
                ACK = 1'b1;
                tick();
                ACK = 1'b0;
            end
        end
        chk("sat_hit_cnt", s_hit, 4'hF);
        chk("sat_no_alarm", s_alarm, 0);
        chk("main_hit_cnt_20", HIT_CNT, 20);

`ifdef TRIG_MON_TIMESTAMP_EN
        do_reset();
        tick(34);
        TRIG_NETS = 8'hFF;
        tick();
        TRIG_NETS = 8'h00;
        tick();
        chk("tstamp_cycle37", TSTAMP, 37);
`endif

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
